// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: buffers fetched words with their PC and presents the
// head word to the decoder split into opcode/operand fields.
module instr_prefetch_queue #(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 3,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [ADDR_W-1:0]          in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPC_W-1:0]           opcode,
    output logic [DATA_W-OPC_W-1:0]    operand,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_word;

    // Refusing pushes while full (even with a pop) keeps in_ready independent of out_ready.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head_word = out_valid ? data_mem[rd_ptr] : '0;
    assign opcode    = head_word[DATA_W-1 -: OPC_W];
    assign operand   = head_word[DATA_W-OPC_W-1:0];
    assign out_pc    = out_valid ? pc_mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push && !flush) begin
            data_mem[wr_ptr] <= in_data;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    // Flush outranks any same-cycle push or pop; pointers wrap via natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a queue model for the streaming and
// random sections.
module tb_instr_prefetch_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [4:0] in_pc;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic [4:0] out_pc;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;
    logic [12:0] sb [$];

    always #5 clk = ~clk;

    instr_prefetch_queue #(
        .DATA_W(8), .OPC_W(3), .ADDR_W(5), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .operand(operand), .out_pc(out_pc), .count(count)
    );

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [4:0] p,
                                 input logic r);
        in_valid  = v;
        in_data   = d;
        in_pc     = p;
        out_ready = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
        checkOutput({tag, "_opcode"}, 32'(opcode), 32'd0);
        checkOutput({tag, "_operand"}, 32'(operand), 32'd0);
        checkOutput({tag, "_pc"}, 32'(out_pc), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0);
        tick();
        tick();
        checkIdle("reset");
        reset = 1'b0;
        tick();

        // Single word: field split and PC carried through.
        applyStimulus(1'b1, 8'b101_10011, 5'd5, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0);
        checkOutput("single_valid", 32'(out_valid), 32'd1);
        checkOutput("single_opcode", 32'(opcode), 32'b101);
        checkOutput("single_operand", 32'(operand), 32'b10011);
        checkOutput("single_pc", 32'(out_pc), 32'd5);
        checkOutput("single_count", 32'(count), 32'd1);
        tick();
        checkOutput("hold_opcode", 32'(opcode), 32'b101);
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b1);
        tick();
        checkIdle("single_pop");

        // Fill to full, attempt fifth push, drain in order.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h11 * (i + 1)), 5'(10 + i), 1'b0);
            tick();
        end
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 8'h55, 5'd20, 1'b1);
        tick();
        checkOutput("refused_count", 32'(count), 32'd3);
        checkOutput("refused_head", 32'({opcode, operand}), 32'h22);
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            checkOutput("drain_data", 32'({opcode, operand}), 32'(8'h11 * (i + 1)));
            checkOutput("drain_pc", 32'(out_pc), 32'(10 + i));
            tick();
        end
        checkIdle("drain_end");

        // Steady push+pop at count=2 across pointer wrap.
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 8'(8'hA0 + i), 5'(i), 1'b0);
            sb.push_back({5'(i), 8'(8'hA0 + i)});
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(8'hC0 + i), 5'(16 + i), 1'b1);
            checkOutput("stream_data", 32'({opcode, operand}), 32'(sb[0][7:0]));
            checkOutput("stream_pc", 32'(out_pc), 32'(sb[0][12:8]));
            void'(sb.pop_front());
            sb.push_back({5'(16 + i), 8'(8'hC0 + i)});
            tick();
            checkOutput("stream_count", 32'(count), 32'd2);
        end
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checkOutput("stream_tail", 32'({opcode, operand}), 32'(sb[0][7:0]));
            void'(sb.pop_front());
            tick();
        end
        checkOutput("stream_empty", 32'(count), 32'd0);

        // Flush with a simultaneous push: 0x77 must vanish.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'h61 + i), 5'(i), 1'b0);
            tick();
        end
        checkOutput("preflush_count", 32'(count), 32'd3);
        applyStimulus(1'b1, 8'h77, 5'd7, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0);
        checkIdle("flush");
        applyStimulus(1'b1, 8'h88, 5'd8, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b1);
        checkOutput("postflush_head", 32'({opcode, operand}), 32'h88);
        checkOutput("postflush_pc", 32'(out_pc), 32'd8);
        tick();
        checkOutput("postflush_count", 32'(count), 32'd0);

        // Mid-stream async reset with three entries queued.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'h31 + i), 5'(i + 1), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0);
        checkOutput("prereset_count", 32'(count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        checkIdle("midreset");
        tick();
        reset = 1'b0;
        tick();

        // Random valid/ready traffic against the queue model.
        sb.delete();
        for (int i = 0; i < 1000; i++) begin
            logic v, r, do_push, do_pop;
            logic [7:0] d;
            logic [4:0] p;
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            p = 5'($urandom);
            applyStimulus(v, d, p, r);
            #1;
            checkOutput("rand_count", 32'(count), 32'(sb.size()));
            if (sb.size() != 0) begin
                checkOutput("rand_head", 32'({out_pc, opcode, operand}), 32'(sb[0]));
            end
            do_push = v && (sb.size() != 4);
            do_pop  = r && (sb.size() != 0);
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back({p, d});
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 8'h00, 5'd0, 1'b0);
        checkOutput("rand_final_count", 32'(count), 32'(sb.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
